// File: rtl/rpn_calc_pkg.sv
// rpn_calc_pkg
//   Shared types for the RPN stack calculator: ALU opcodes, control FSM
//   states, undo snapshot kinds and bit positions inside the {N,Z,C,V}
//   flag vector.
package rpn_calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } opcode_t;

    // Encodings are visible on status[1:0].
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        SNAP_NONE = 2'b00,
        SNAP_PUSH = 2'b01,
        SNAP_OP   = 2'b10
    } snap_kind_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/rpn_alu.sv
// rpn_alu
//   Combinational ALU for the RPN calculator.
//   a, b   : operands (a = second-from-top, b = top of stack)
//   op     : ADD, SUB (a-b), AND, OR
//   result : a op b truncated to WIDTH
//   flags  : {N,Z,C,V}; C is carry for ADD and borrow for SUB,
//            C and V are 0 for logic ops
module rpn_alu
    import rpn_calc_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  opcode_t          op,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic [WIDTH:0] ext;
    logic           carry;
    logic           ovf;

    always_comb begin
        ext    = '0;
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                ext    = {1'b0, a} + {1'b0, b};
                result = ext[WIDTH-1:0];
                carry  = ext[WIDTH];
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Zero-extended subtraction wraps into bit WIDTH exactly when a < b.
                ext    = {1'b0, a} - {1'b0, b};
                result = ext[WIDTH-1:0];
                carry  = ext[WIDTH];
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            default: result = '0;
        endcase

        flags         = '0;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/rpn_stack_calc.sv
// rpn_stack_calc
//   RPN calculator with a DEPTH-entry operand stack and one-level undo.
//   clk, reset  : system clock, synchronous active-high reset
//   enter_pulse : push data_in (is_op=0) or apply opcode data_in[1:0] (is_op=1)
//   undo_pulse  : revert the last accepted push or op
//   to_display  : top of stack, 0 when empty
//   flags       : {N,Z,C,V} of the last executed op
//   status      : {sticky error, state[1:0]}
//   count       : stack occupancy
//   busy        : high during the EXEC cycle, when pulses are ignored
module rpn_stack_calc
    import rpn_calc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter_pulse,
    input  logic             undo_pulse,
    input  logic             is_op,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] to_display,
    output logic [3:0]       flags,
    output logic [2:0]       status,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    opcode_t          op_q, op_d;
    logic [3:0]       flags_q, flags_d;
    logic [3:0]       snap_flags_q, snap_flags_d;
    snap_kind_t       snap_q, snap_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;
    logic [IDX_W-1:0] top_idx, sec_idx, cnt_idx;

    rpn_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_comb begin
        top_idx = IDX_W'(count_q - CNT_W'(1));
        sec_idx = IDX_W'(count_q - CNT_W'(2));
        cnt_idx = IDX_W'(count_q);
    end

    // The operand registers double as the undo snapshot of A and B: they are
    // only reloaded by the next op, which also replaces the snapshot.
    always_comb begin
        stack_d      = stack_q;
        count_d      = count_q;
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        flags_d      = flags_q;
        snap_flags_d = snap_flags_q;
        snap_d       = snap_q;
        err_d        = err_q;

        case (state_q)
            S_EXEC: begin
                stack_d[sec_idx] = alu_result;
                count_d          = count_q - CNT_W'(1);
                flags_d          = alu_flags;
                state_d          = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
                if (enter_pulse) begin
                    if (is_op) begin
                        if (count_q >= CNT_W'(2)) begin
                            a_d          = stack_q[sec_idx];
                            b_d          = stack_q[top_idx];
                            op_d         = opcode_t'(data_in[1:0]);
                            snap_flags_d = flags_q;
                            snap_d       = SNAP_OP;
                            err_d        = 1'b0;
                            state_d      = S_EXEC;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        if (count_q < CNT_W'(DEPTH)) begin
                            stack_d[cnt_idx] = data_in;
                            count_d          = count_q + CNT_W'(1);
                            snap_d           = SNAP_PUSH;
                            err_d            = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else if (undo_pulse) begin
                    case (snap_q)
                        SNAP_PUSH: begin
                            count_d = count_q - CNT_W'(1);
                            snap_d  = SNAP_NONE;
                            err_d   = 1'b0;
                        end
                        SNAP_OP: begin
                            // Result sits at top_idx; A goes back there, B above it.
                            stack_d[top_idx] = a_q;
                            stack_d[cnt_idx] = b_q;
                            count_d          = count_q + CNT_W'(1);
                            flags_d          = snap_flags_q;
                            snap_d           = SNAP_NONE;
                            err_d            = 1'b0;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
            count_q      <= '0;
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_ADD;
            flags_q      <= '0;
            snap_flags_q <= '0;
            snap_q       <= SNAP_NONE;
            err_q        <= 1'b0;
        end else begin
            stack_q      <= stack_d;
            count_q      <= count_d;
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            flags_q      <= flags_d;
            snap_flags_q <= snap_flags_d;
            snap_q       <= snap_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        to_display = (count_q == '0) ? '0 : stack_q[top_idx];
        flags      = flags_q;
        status     = {err_q, state_q};
        count      = count_q;
        busy       = (state_q == S_EXEC);
    end

endmodule

// File: doc/rpn_stack_calc.md
Name: rpn_stack_calc

Overview:
- Parametrised successor to the two-operand Reverse Polish Notation (RPN) calculator. An operand stack of DEPTH entries replaces the fixed A/B/OpCode registers.
- Accepts already-debounced enter and undo pulses. Data is either pushed as an operand or applied as an opcode to the top two entries.
- Provides one-level undo of the last accepted action.
- Sits between the debouncer_FSM instances and the display selector/flag LEDs.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
DEPTH, 4, stack entries (>=2)
CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enter_pulse  in  1  one-cycle debounced Enter pulse
undo_pulse  in  1  one-cycle debounced Undo pulse
is_op  in  1  sampled with enter_pulse: 1 = data_in[1:0] is an opcode, 0 = data_in is an operand
data_in  in  WIDTH  operand or opcode
to_display  out  WIDTH  top of stack; 0 when empty
flags  out  4  {N,Z,C,V} of last executed op
status  out  3  {error, state[1:0]}
count  out  CNT_W  current stack occupancy
busy  out  1  high while in EXEC

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named clk and reset.
- Reset:
  - stack cleared, count=0, to_display=0, flags=0, status=000, busy=0.
  - undo snapshot invalid, state IDLE.
  - Reset wins over every other input in the same cycle, including mid-EXEC; the operation in flight is discarded.
- States (status[1:0]): IDLE=00, EXEC=01, DONE=10.
  - IDLE --enter&is_op&count>=2--> EXEC --> DONE --> IDLE.
  - Push does not leave IDLE.
  - DONE lasts one cycle; pulses arriving in DONE are accepted as in IDLE.
- Push (IDLE or DONE, enter_pulse, is_op=0, count<DEPTH):
  - data_in written to stack[count]; count+1 on the next edge.
  - to_display = data_in one cycle after the pulse.
  - Snapshot records "push".
- Op (enter_pulse, is_op=1, count>=2):
  - A = second-from-top, B = top; sampled into operand registers on the pulse edge.
  - EXEC cycle: combinational ALU evaluates A op B.
  - End of EXEC: A and B are replaced by the result, count-1, flags updated.
  - Result visible 2 cycles after the pulse.
  - Snapshot stores A, B and the previous flags.
- Opcodes: 00 ADD, 01 SUB (A-B), 10 AND, 11 OR. Result truncated to WIDTH.
- Flags:
  - N = result[WIDTH-1]; Z = (result==0).
  - C = carry-out for ADD, borrow (A<B unsigned) for SUB, 0 for logic ops.
  - V = signed overflow for ADD/SUB, 0 for logic ops.
- Errors (status[2], sticky until the next accepted enter or undo, or reset). The request is ignored and state is unchanged in each case:
  - push when count==DEPTH (full);
  - op when count<2;
  - undo with no valid snapshot.
- Undo (IDLE or DONE, undo_pulse):
  - After a push: pop, count-1.
  - After an op: result removed; A and B restored; count+1; flags restored.
  - In both cases the snapshot then becomes invalid, so a second undo is an error.
- Simultaneous enter_pulse and undo_pulse: enter wins, undo dropped.
- Pulses arriving in EXEC are ignored; busy=1 flags this.
- Empty stack: to_display=0.
- Full stack: op still permitted because it frees one entry.

Decomposition:
- Package rpn_calc_pkg:
  - opcode_t enum (OP_ADD, OP_SUB, OP_AND, OP_OR);
  - state_t enum (S_IDLE, S_EXEC, S_DONE);
  - flag bit-index localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - snapshot kind enum (SNAP_NONE, SNAP_PUSH, SNAP_OP).
- Sub-module rpn_alu: combinational, parametrised WIDTH, produces result and flags.
- Stack, FSM and undo snapshot remain in rpn_stack_calc.

Test Plan:
- WIDTH=16, DEPTH=4. Reset; push 5, push 3, op SUB -> 2 cycles after the op pulse: to_display=0x0002, count=1, flags=0000, status=010 for one cycle, then 000.
- Push 3, push 5, op SUB -> to_display=0xFFFE, flags=1010 (N,C); then undo -> count=2, to_display=0x0005, flags=0000; a second undo -> status[2]=1, count=2.
- Push 0x7FFF, push 0x0001, op ADD -> to_display=0x8000, flags=1001 (N,V).
- Push 1,2,3,4 then push 9 -> status[2]=1, count=4, to_display=0x0004. Then op AND -> 3&4=0x0000, flags=0100, count=3, error cleared.
- Empty stack: op -> error, count=0, to_display=0. Enter and undo in the same cycle with is_op=0, data 7 -> push of 7 only, count=1.
- Push 6, push 2, op ADD, assert reset during EXEC -> next cycle count=0, to_display=0, flags=0, status=000, busy=0.
